// File: rtl/llc_pipe_pkg.sv
// Shared LLC pipeline types: geometry, request metadata, the mem->lookup packet
// and helpers that splice one way into a packed tag/state row.
package llc_pipe_pkg;

  localparam int LLC_SET_BITS   = 8;
  localparam int LLC_TAG_BITS   = 16;
  localparam int LLC_WAYS       = 8;
  localparam int LLC_WAY_BITS   = $clog2(LLC_WAYS);
  localparam int LLC_STATE_BITS = 2;

  typedef enum logic [LLC_STATE_BITS-1:0] {
    LLC_INVALID  = 2'd0,
    LLC_VALID    = 2'd1,
    LLC_SHARED   = 2'd2,
    LLC_MODIFIED = 2'd3
  } llc_state_t;

  typedef logic [LLC_WAYS*LLC_TAG_BITS-1:0]   llc_tag_row_t;
  typedef logic [LLC_WAYS*LLC_STATE_BITS-1:0] llc_state_row_t;

  // Opaque to this stage; carried from the arbiter to lookup untouched.
  typedef struct packed {
    logic [3:0] req_id;
    logic [3:0] msg;
  } llc_rd_meta_t;

  typedef struct packed {
    logic [LLC_TAG_BITS-1:0] tag_input;
    logic [LLC_SET_BITS-1:0] set;
    llc_tag_row_t            rd_tags_pipeline;
    llc_state_row_t          rd_states_pipeline;
    logic [LLC_WAY_BITS-1:0] rd_evict_way_pipeline;
    llc_rd_meta_t            meta;
  } fifo_mem_lookup_packet;

  function automatic llc_tag_row_t tag_row_put(input llc_tag_row_t row,
                                               input logic [LLC_WAY_BITS-1:0] way,
                                               input logic [LLC_TAG_BITS-1:0] tag);
    llc_tag_row_t r;
    r = row;
    r[way*LLC_TAG_BITS +: LLC_TAG_BITS] = tag;
    return r;
  endfunction

  function automatic llc_state_row_t state_row_put(input llc_state_row_t row,
                                                   input logic [LLC_WAY_BITS-1:0] way,
                                                   input logic [LLC_STATE_BITS-1:0] state);
    llc_state_row_t r;
    r = row;
    r[way*LLC_STATE_BITS +: LLC_STATE_BITS] = state;
    return r;
  endfunction

endpackage

// File: rtl/llc_rd_buf.sv
// Circular output buffer of mem->lookup packets with push/pop/clear; with
// LLC_RD_BYPASS_EN defined it also exposes a set-match in-place update port.
module llc_rd_buf
  import llc_pipe_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  fifo_mem_lookup_packet         push_data_i,
  input  logic                          pop_i,
`ifdef LLC_RD_BYPASS_EN
  input  logic                          upd_en_i,
  input  logic [LLC_SET_BITS-1:0]       upd_set_i,
  input  logic [LLC_WAY_BITS-1:0]       upd_way_i,
  input  logic [LLC_TAG_BITS-1:0]       upd_tag_i,
  input  logic [LLC_STATE_BITS-1:0]     upd_state_i,
  input  logic                          upd_evict_en_i,
  input  logic [LLC_WAY_BITS-1:0]       upd_evict_way_i,
`endif
  output fifo_mem_lookup_packet         head_o,
  output logic [$clog2(BUF_DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_mem_lookup_packet mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  // Clear wins over everything else in its cycle.
  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && (count_q != '0);

  // NOTE: state uses <= so every register samples pre-edge values in one step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // BUF_DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage is not reset; count_q alone qualifies its contents.
  always_ff @(posedge clk) begin
`ifdef LLC_RD_BYPASS_EN
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (upd_en_i && mem_q[i].set == upd_set_i) begin
        mem_q[i].rd_tags_pipeline   <= tag_row_put(mem_q[i].rd_tags_pipeline, upd_way_i, upd_tag_i);
        mem_q[i].rd_states_pipeline <= state_row_put(mem_q[i].rd_states_pipeline, upd_way_i, upd_state_i);
      end
      if (upd_evict_en_i && mem_q[i].set == upd_set_i)
        mem_q[i].rd_evict_way_pipeline <= upd_evict_way_i;
    end
`endif
    // The pushed row already carries any same-cycle forward, so it overrides.
    if (do_push) mem_q[tail_q] <= push_data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[head_q] : '0;
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(do_push && !do_pop && count_q == CNT_W'(BUF_DEPTH)));

endmodule

// File: rtl/llc_mem_rd_stage.sv
// LLC memory read stage: accepts set/tag requests, reads tag/state/evict SRAMs
// (1-cycle latency) and queues rows for lookup. Optional LLC_RD_BYPASS_EN forwards writes.
module llc_mem_rd_stage
  import llc_pipe_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LLC_SET_BITS-1:0]             in_set,
  input  logic [LLC_TAG_BITS-1:0]             in_tag,
  input  llc_rd_meta_t                        in_meta,
  output logic                                rd_en,
  output logic [LLC_SET_BITS-1:0]             rd_set,
  input  logic [LLC_WAYS*LLC_TAG_BITS-1:0]    rd_tags,
  input  logic [LLC_WAYS*LLC_STATE_BITS-1:0]  rd_states,
  input  logic [LLC_WAY_BITS-1:0]             rd_evict_way,
  input  logic                                wr_en,
  input  logic [LLC_SET_BITS-1:0]             wr_set,
  input  logic [LLC_WAY_BITS-1:0]             wr_way,
  input  logic [LLC_TAG_BITS-1:0]             wr_tag,
  input  logic [LLC_STATE_BITS-1:0]           wr_state,
  input  logic                                wr_evict_en,
  input  logic [LLC_WAY_BITS-1:0]             wr_evict_way,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output fifo_mem_lookup_packet               out_pkt,
  output logic                                busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic                    cap_valid_q, cap_valid_d;
  logic [LLC_SET_BITS-1:0] cap_set_q, cap_set_d;
  logic [LLC_TAG_BITS-1:0] cap_tag_q, cap_tag_d;
  llc_rd_meta_t            cap_meta_q, cap_meta_d;

  logic [CNT_W-1:0]        count;
  logic [CNT_W:0]          occupancy;
  logic                    pop, accept, push, wr_stall;
  fifo_mem_lookup_packet   cap_pkt;

  assign pop = out_valid && out_ready;

`ifdef LLC_RD_BYPASS_EN
  // A read of the set being written this cycle would race the SRAM write.
  assign wr_stall = wr_en && (wr_set == in_set);
`else
  logic unused_wr;
  assign wr_stall  = 1'b0;
  assign unused_wr = ^{wr_en, wr_set, wr_way, wr_tag, wr_state, wr_evict_en, wr_evict_way};
`endif

  // Slots already promised: buffered rows plus the read in flight, less the one leaving.
  assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(cap_valid_q) - (CNT_W+1)'(pop);
  assign in_ready  = rst && !flush && !wr_stall && (occupancy < (CNT_W+1)'(BUF_DEPTH));
  assign accept    = in_valid && in_ready;
  assign rd_en     = accept;
  assign rd_set    = accept ? in_set : '0;

  // NOTE: every variable gets a default first, so no path infers a latch.
  always_comb begin
    cap_valid_d = accept;
    cap_set_d   = cap_set_q;
    cap_tag_d   = cap_tag_q;
    cap_meta_d  = cap_meta_q;
    if (accept) begin
      cap_set_d  = in_set;
      cap_tag_d  = in_tag;
      cap_meta_d = in_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_valid_q <= 1'b0;
      cap_set_q   <= '0;
      cap_tag_q   <= '0;
      cap_meta_q  <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_set_q   <= cap_set_d;
      cap_tag_q   <= cap_tag_d;
      cap_meta_q  <= cap_meta_d;
    end
  end

  always_comb begin
    cap_pkt                       = '0;
    cap_pkt.tag_input             = cap_tag_q;
    cap_pkt.set                   = cap_set_q;
    cap_pkt.meta                  = cap_meta_q;
    cap_pkt.rd_tags_pipeline      = rd_tags;
    cap_pkt.rd_states_pipeline    = rd_states;
    cap_pkt.rd_evict_way_pipeline = rd_evict_way;
`ifdef LLC_RD_BYPASS_EN
    if (wr_en && wr_set == cap_set_q) begin
      cap_pkt.rd_tags_pipeline   = tag_row_put(rd_tags, wr_way, wr_tag);
      cap_pkt.rd_states_pipeline = state_row_put(rd_states, wr_way, wr_state);
    end
    if (wr_evict_en && wr_set == cap_set_q)
      cap_pkt.rd_evict_way_pipeline = wr_evict_way;
`endif
  end

  // A flush discards the row returning from the SRAM this cycle.
  assign push = cap_valid_q && !flush;

  llc_rd_buf #(
    .BUF_DEPTH       (BUF_DEPTH)
  ) u_buf (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (flush),
    .push_i          (push),
    .push_data_i     (cap_pkt),
    .pop_i           (pop),
`ifdef LLC_RD_BYPASS_EN
    .upd_en_i        (wr_en),
    .upd_set_i       (wr_set),
    .upd_way_i       (wr_way),
    .upd_tag_i       (wr_tag),
    .upd_state_i     (wr_state),
    .upd_evict_en_i  (wr_evict_en),
    .upd_evict_way_i (wr_evict_way),
`endif
    .head_o          (out_pkt),
    .count_o         (count)
  );

  assign out_valid = (count != '0);
  assign busy      = cap_valid_q || out_valid;

endmodule

// File: tb/tb_llc_mem_rd_stage.sv
// Self-checking bench for llc_mem_rd_stage: SRAM model, scoreboard queue and
// directed scenarios; bypass expectations follow LLC_RD_BYPASS_EN.
module tb_llc_mem_rd_stage;
  import llc_pipe_pkg::*;

  typedef logic [255:0] w_t;

  logic                               clk, rst;
  logic                               in_valid, in_ready;
  logic [LLC_SET_BITS-1:0]            in_set;
  logic [LLC_TAG_BITS-1:0]            in_tag;
  llc_rd_meta_t                       in_meta;
  logic                               rd_en;
  logic [LLC_SET_BITS-1:0]            rd_set;
  logic [LLC_WAYS*LLC_TAG_BITS-1:0]   rd_tags;
  logic [LLC_WAYS*LLC_STATE_BITS-1:0] rd_states;
  logic [LLC_WAY_BITS-1:0]            rd_evict_way;
  logic                               wr_en, wr_evict_en;
  logic [LLC_SET_BITS-1:0]            wr_set;
  logic [LLC_WAY_BITS-1:0]            wr_way, wr_evict_way;
  logic [LLC_TAG_BITS-1:0]            wr_tag;
  logic [LLC_STATE_BITS-1:0]          wr_state;
  logic                               flush, out_valid, out_ready, busy;
  fifo_mem_lookup_packet              out_pkt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  fifo_mem_lookup_packet sb_q[$];
  fifo_mem_lookup_packet sb_exp;
  fifo_mem_lookup_packet e;

  llc_mem_rd_stage #(.BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_set(in_set), .in_tag(in_tag), .in_meta(in_meta),
    .rd_en(rd_en), .rd_set(rd_set), .rd_tags(rd_tags), .rd_states(rd_states), .rd_evict_way(rd_evict_way),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag), .wr_state(wr_state),
    .wr_evict_en(wr_evict_en), .wr_evict_way(wr_evict_way),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents are a fixed function of the set.
  function automatic llc_tag_row_t sram_tags(input logic [LLC_SET_BITS-1:0] s);
    llc_tag_row_t r;
    for (int w = 0; w < LLC_WAYS; w++) r[w*LLC_TAG_BITS +: LLC_TAG_BITS] = {s, 4'hA, 4'(w)};
    return r;
  endfunction

  function automatic llc_state_row_t sram_states(input logic [LLC_SET_BITS-1:0] s);
    llc_state_row_t r;
    for (int w = 0; w < LLC_WAYS; w++) r[w*LLC_STATE_BITS +: LLC_STATE_BITS] = 2'(s + 8'(w));
    return r;
  endfunction

  function automatic fifo_mem_lookup_packet exp_pkt(input logic [LLC_SET_BITS-1:0] s,
                                                    input logic [LLC_TAG_BITS-1:0] t,
                                                    input llc_rd_meta_t m);
    fifo_mem_lookup_packet p;
    p.tag_input             = t;
    p.set                   = s;
    p.rd_tags_pipeline      = sram_tags(s);
    p.rd_states_pipeline    = sram_states(s);
    p.rd_evict_way_pipeline = s[LLC_WAY_BITS-1:0];
    p.meta                  = m;
    return p;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rd_tags      <= sram_tags(rd_set);
      rd_states    <= sram_states(rd_set);
      rd_evict_way <= rd_set[LLC_WAY_BITS-1:0];
    end
  end

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int s, input int t, input int m);
    in_valid = 1'b1;
    in_set   = LLC_SET_BITS'(s);
    in_tag   = LLC_TAG_BITS'(t);
    in_meta  = llc_rd_meta_t'(8'(m));
  endtask

  // Scoreboard: pop/compare, then apply process-stage writes, then push accepts.
  always @(negedge clk) begin
    if (!rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_has_entry", w_t'(sb_q.size() != 0), w_t'(1));
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          check("sb_pkt", w_t'(out_pkt), w_t'(sb_exp));
          n_pops++;
        end
      end
`ifdef LLC_RD_BYPASS_EN
      foreach (sb_q[i]) begin
        if (wr_en && sb_q[i].set == wr_set) begin
          sb_q[i].rd_tags_pipeline   = tag_row_put(sb_q[i].rd_tags_pipeline, wr_way, wr_tag);
          sb_q[i].rd_states_pipeline = state_row_put(sb_q[i].rd_states_pipeline, wr_way, wr_state);
        end
        if (wr_evict_en && sb_q[i].set == wr_set) sb_q[i].rd_evict_way_pipeline = wr_evict_way;
      end
`endif
      if (in_valid && in_ready) sb_q.push_back(exp_pkt(in_set, in_tag, in_meta));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_tag = '0; wr_state = '0;
    wr_evict_en = 1'b0; wr_evict_way = '0;
    rd_tags = '0; rd_states = '0; rd_evict_way = '0;
    drive_req(3, 16'h0033, 0);
    #12;
    check("rst_in_ready", w_t'(in_ready), w_t'(0));
    check("rst_rd_en", w_t'(rd_en), w_t'(0));
    check("rst_rd_set", w_t'(rd_set), w_t'(0));
    check("rst_out_valid", w_t'(out_valid), w_t'(0));
    check("rst_out_pkt", w_t'(out_pkt), w_t'(0));
    check("rst_busy", w_t'(busy), w_t'(0));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_rel_in_ready", w_t'(in_ready), w_t'(1));
    tick();

    // Single request: rd at T, data at T+1, out_valid at T+2.
    drive_req(5, 16'h001A, 8'h3C); #1;
    check("t1_in_ready", w_t'(in_ready), w_t'(1));
    check("t1_rd_en", w_t'(rd_en), w_t'(1));
    check("t1_rd_set", w_t'(rd_set), w_t'(5));
    tick(); in_valid = 1'b0; #1;
    check("t1_busy_T1", w_t'(busy), w_t'(1));
    check("t1_out_valid_T1", w_t'(out_valid), w_t'(0));
    tick();
    check("t1_out_valid_T2", w_t'(out_valid), w_t'(1));
    check("t1_pkt", w_t'(out_pkt), w_t'(exp_pkt(5, 16'h001A, 8'h3C)));
    out_ready = 1'b1;
    tick();
    check("t1_out_valid_after", w_t'(out_valid), w_t'(0));
    check("t1_busy_after", w_t'(busy), w_t'(0));

    // Back-to-back stream of 8 with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      drive_req(10 + i, 16'h0100 + i, i); #1;
      check("t2_in_ready", w_t'(in_ready), w_t'(1));
      if (i >= 2) check("t2_out_valid", w_t'(out_valid), w_t'(1));
      tick();
    end
    in_valid = 1'b0; #1;
    check("t2_busy_L1", w_t'(busy), w_t'(1));
    tick();
    check("t2_busy_L2", w_t'(busy), w_t'(1));
    tick();
    check("t2_busy_L3", w_t'(busy), w_t'(0));
    check("t2_out_valid_L3", w_t'(out_valid), w_t'(0));

    // Backpressure: two accepted, third stalls, head holds.
    out_ready = 1'b0;
    drive_req(50, 16'h0500, 1); #1;
    check("t3_in_ready0", w_t'(in_ready), w_t'(1));
    tick();
    drive_req(51, 16'h0501, 2); #1;
    check("t3_in_ready1", w_t'(in_ready), w_t'(1));
    tick();
    drive_req(52, 16'h0502, 3); #1;
    check("t3_stall_c2", w_t'(in_ready), w_t'(0));
    tick();
    check("t3_stall_c3", w_t'(in_ready), w_t'(0));
    check("t3_head_c3", w_t'(out_pkt), w_t'(exp_pkt(50, 16'h0500, 1)));
    tick();
    check("t3_head_c4", w_t'(out_pkt), w_t'(exp_pkt(50, 16'h0500, 1)));
    out_ready = 1'b1; #1;
    check("t3_ready_comb", w_t'(in_ready), w_t'(1));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("t3_drained", w_t'(out_valid), w_t'(0));

    // Flush with one read in flight and one row buffered (the most BUF_DEPTH=2 admits).
    out_ready = 1'b0;
    drive_req(20, 16'h0200, 4); tick();
    drive_req(21, 16'h0201, 5); tick();
    drive_req(22, 16'h0202, 6); flush = 1'b1; #1;
    check("t4_flush_in_ready", w_t'(in_ready), w_t'(0));
    check("t4_flush_rd_en", w_t'(rd_en), w_t'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("t4_out_valid", w_t'(out_valid), w_t'(0));
    check("t4_busy", w_t'(busy), w_t'(0));
    check("t4_in_ready", w_t'(in_ready), w_t'(1));
    out_ready = 1'b1;
    drive_req(23, 16'h0203, 7); tick();
    in_valid = 1'b0; tick();
    check("t4_post_valid", w_t'(out_valid), w_t'(1));
    check("t4_post_pkt", w_t'(out_pkt), w_t'(exp_pkt(23, 16'h0203, 7)));
    tick();

    // Process-stage write to set 5 way 3 while one set-5 row is buffered and one captured.
    out_ready = 1'b0;
    drive_req(5, 16'h0055, 1); tick();
    drive_req(5, 16'h0066, 2); tick();
    in_valid = 1'b0;
    wr_en = 1'b1; wr_set = 8'd5; wr_way = 3'd3; wr_tag = 16'hBEEF; wr_state = LLC_VALID;
    wr_evict_en = 1'b1; wr_evict_way = 3'd6;
    tick();
    wr_en = 1'b0; wr_evict_en = 1'b0; #1;
    e = exp_pkt(5, 16'h0055, 1);
`ifdef LLC_RD_BYPASS_EN
    e.rd_tags_pipeline      = tag_row_put(e.rd_tags_pipeline, 3'd3, 16'hBEEF);
    e.rd_states_pipeline    = state_row_put(e.rd_states_pipeline, 3'd3, LLC_VALID);
    e.rd_evict_way_pipeline = 3'd6;
`endif
    check("t5_head", w_t'(out_pkt), w_t'(e));
    out_ready = 1'b1;
    repeat (3) tick();
    // Write to the requested set in the accept cycle.
    drive_req(9, 16'h0099, 9);
    wr_en = 1'b1; wr_set = 8'd9; #1;
`ifdef LLC_RD_BYPASS_EN
    check("t5_wr_stall", w_t'(in_ready), w_t'(0));
`else
    check("t5_wr_stall", w_t'(in_ready), w_t'(1));
`endif
    tick();
    in_valid = 1'b0; wr_en = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-stream with two rows buffered.
    out_ready = 1'b0;
    drive_req(30, 16'h0300, 10); tick();
    drive_req(31, 16'h0301, 11); tick();
    drive_req(40, 16'h0400, 12); tick();
    check("t6_pre_valid", w_t'(out_valid), w_t'(1));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_out_valid", w_t'(out_valid), w_t'(0));
    check("t6_rst_busy", w_t'(busy), w_t'(0));
    check("t6_rst_in_ready", w_t'(in_ready), w_t'(0));
    check("t6_rst_rd_en", w_t'(rd_en), w_t'(0));
    check("t6_rst_rd_set", w_t'(rd_set), w_t'(0));
    check("t6_rst_out_pkt", w_t'(out_pkt), w_t'(0));
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("t6_rel_in_ready", w_t'(in_ready), w_t'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale", w_t'(out_valid), w_t'(0));
    end
    drive_req(41, 16'h0401, 13); tick();
    in_valid = 1'b0; tick();
    check("t6_post_pkt", w_t'(out_pkt), w_t'(exp_pkt(41, 16'h0401, 13)));
    repeat (3) tick();

    check("sb_empty_end", w_t'(sb_q.size()), w_t'(0));
`ifdef LLC_RD_BYPASS_EN
    check("total_delivered", w_t'(n_pops), w_t'(16));
`else
    check("total_delivered", w_t'(n_pops), w_t'(17));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
